onehot_drain_encoder: RTL and testbench
=======================================

Name: onehot_drain_encoder

Overview:
- Inverse of the address decoder: takes a multi-hot wire vector and emits the index of every set bit, one index per handshake.
- Sits between request/interrupt-style wire vectors and index-based consumers, such as arbiter grant logging or IRQ-to-ID conversion.
- Valid/ready on both sides. Input vector is captured, then drained bit by bit, lowest index first by default.

Parameters:
- NUM_WIRE, 4, number of input wires; must be >= 2; index width AW = $clog2(NUM_WIRE).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- d_i  input  NUM_WIRE  multi-hot wire vector
- d_valid_i  input  1  d_i is valid
- d_ready_o  output  1  block can capture d_i
- a_o  output  AW  index of the current set bit
- a_last_o  output  1  current index is the final set bit of the captured vector
- a_valid_o  output  1  a_o / a_last_o valid
- a_ready_i  input  1  consumer accepts a_o
- drop_o  output  1  one-cycle pulse: all-zero vector accepted and discarded

Behaviour:
- Registers: state, pending[NUM_WIRE], drop_q.
  - Reset (rst_i=1 at edge): state=IDLE, pending=0, drop_q=0.
  - Outputs after reset: d_ready_o=1, a_valid_o=0, a_o=0, a_last_o=0, drop_o=0.
- States: IDLE, DRAIN.
  - d_ready_o = (state==IDLE). It depends only on state, with no combinational path from a_ready_i.
  - a_valid_o = (state==DRAIN).
- IDLE, on d_valid_i & d_ready_o:
  - If d_i != 0: pending <= d_i, go to DRAIN.
  - If d_i == 0: stay in IDLE, drop_q <= 1 for exactly one cycle. No output beat.
- DRAIN outputs:
  - a_o = index of lowest set bit of pending, combinational from the registered pending.
  - a_last_o = (pending has exactly one bit set).
- DRAIN, on a_valid_o & a_ready_i:
  - Clear pending[a_o].
  - If a_last_o: pending becomes 0, go to IDLE.
- Stall: while a_ready_i=0, a_o, a_last_o and a_valid_o are held stable. Valid is never withdrawn.
- Latency: vector accepted at edge N gives first a_valid_o=1 in cycle N+1.
  - k set bits with a_ready_i held high take k cycles.
  - d_ready_o returns to 1 in the cycle after the last beat, so there is 1 bubble cycle between vectors.
- d_i is ignored outside IDLE. The upstream must hold its valid until it sees ready.
- All-ones vector: NUM_WIRE beats with indices 0..NUM_WIRE-1. a_last_o=1 only on index NUM_WIRE-1.
- Non-power-of-2 NUM_WIRE: a_o never exceeds NUM_WIRE-1.
- Reset mid-DRAIN: pending is discarded, next cycle is IDLE. No further beats for that vector.

Optional Feature:
- Macro: ONEHOT_DRAIN_ENCODER_MSB_FIRST_EN.
- Defined: drain order is highest set index first. a_last_o marks the lowest set bit.
- Undefined (default): lowest set index first, as above.
- Handshake, latency and drop behaviour are identical in both builds.

Decomposition:
- Package onehot_drain_encoder_pkg holds:
  - typedef enum logic {IDLE, DRAIN} onehot_drain_state_e
  - no other shared constants; AW is local.
- One sub-module, priority_encoder #(NUM_WIRE):
  - Combinational; inputs vector_i and msb_first_i (tied by macro); outputs index_o and found_o.
  - Instantiated once on pending.
  - a_last_o is computed as (pending & (pending-1)) == 0 with pending != 0.

Test Plan:
- Single bit: NUM_WIRE=4, d_i=4'b0100, a_ready_i=1 → one beat a_o=2, a_last_o=1, 1 cycle after accept. d_ready_o high again the next cycle.
- Multi-bit with backpressure: d_i=4'b1011, a_ready_i toggling 0/1 → beats 0, 1, 3 in order. a_o held stable while stalled. a_last_o only on 3. Exactly 3 handshakes.
- Zero vector: d_i=0, d_valid_i=1 → drop_o pulses 1 cycle, a_valid_o stays 0, state stays IDLE.
- Back-to-back: vectors 4'b0011 then 4'b1000 with d_valid_i held → beats 0, 1 (last), bubble, then 3 (last). Second vector is captured only when d_ready_o=1.
- Reset mid-drain: d_i=4'b1111, rst_i=1 after the second beat → next cycle a_valid_o=0 and d_ready_o=1. A new vector 4'b0010 then yields a single beat a_o=1.
- MSB-first build, NUM_WIRE=5: d_i=5'b10101 → beats 4, 2, 0, with a_last_o on 0.

Source files
------------

// File: rtl/onehot_drain_encoder_pkg.sv
// onehot_drain_encoder_pkg
// Purpose: shared types for the multi-hot to index drain encoder.
// Contents: drain FSM state enumeration.
package onehot_drain_encoder_pkg;

  typedef enum logic {IDLE, DRAIN} onehot_drain_state_e;

endpackage

// File: rtl/onehot_drain_encoder_if.sv
// onehot_drain_encoder_if
// Purpose: groups the input-vector and output-index handshakes of the drain encoder.
// Signals:
//   d_i / d_valid_i / d_ready_o          multi-hot vector capture handshake
//   a_o / a_last_o / a_valid_o / a_ready_i  index beat handshake
//   drop_o                               pulse when an all-zero vector is discarded
// Modports: slave (encoder side), master (producer/consumer side).
interface onehot_drain_encoder_if #(
  parameter int unsigned NUM_WIRE = 4
);
  localparam int unsigned AW = $clog2(NUM_WIRE);

  logic [NUM_WIRE-1:0] d_i;
  logic                d_valid_i;
  logic                d_ready_o;
  logic [AW-1:0]       a_o;
  logic                a_last_o;
  logic                a_valid_o;
  logic                a_ready_i;
  logic                drop_o;

  modport slave (
    input  d_i, d_valid_i, a_ready_i,
    output d_ready_o, a_o, a_last_o, a_valid_o, drop_o
  );

  modport master (
    output d_i, d_valid_i, a_ready_i,
    input  d_ready_o, a_o, a_last_o, a_valid_o, drop_o
  );

endinterface

// File: rtl/priority_encoder.sv
// priority_encoder
// Purpose: combinational index of the lowest (or highest) set bit of a vector.
// Ports:
//   vector_i     input  NUM_WIRE  vector to search
//   msb_first_i  input  1         1: report highest set bit, 0: lowest set bit
//   index_o      output AW        index of the selected set bit (0 when none)
//   found_o      output 1         vector has at least one bit set
module priority_encoder #(
  parameter int unsigned NUM_WIRE = 4
) (
  input  logic [NUM_WIRE-1:0]         vector_i,
  input  logic                        msb_first_i,
  output logic [$clog2(NUM_WIRE)-1:0] index_o,
  output logic                        found_o
);

  localparam int unsigned AW = $clog2(NUM_WIRE);

  // Later matches overwrite earlier ones, so scan direction sets the priority.
  always_comb begin
    index_o = '0;
    if (msb_first_i) begin
      for (int i = 0; i < int'(NUM_WIRE); i++) begin
        if (vector_i[i]) index_o = AW'(i);
      end
    end else begin
      for (int i = int'(NUM_WIRE) - 1; i >= 0; i--) begin
        if (vector_i[i]) index_o = AW'(i);
      end
    end
  end

  assign found_o = |vector_i;

endmodule

// File: rtl/onehot_drain_encoder.sv
// onehot_drain_encoder
// Purpose: captures a multi-hot vector and emits the index of each set bit,
//          one index per output handshake.
// Ports:
//   clk_i  input  clock, rising edge
//   rst_i  input  synchronous active-high reset
//   bus    onehot_drain_encoder_if.slave (d_i/d_valid_i/d_ready_o,
//          a_o/a_last_o/a_valid_o/a_ready_i, drop_o)
// Build option: ONEHOT_DRAIN_ENCODER_MSB_FIRST_EN drains highest index first;
//               undefined drains lowest index first.
module onehot_drain_encoder
  import onehot_drain_encoder_pkg::*;
#(
  parameter int unsigned NUM_WIRE = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  onehot_drain_encoder_if.slave         bus
);

  localparam int unsigned AW = $clog2(NUM_WIRE);

  onehot_drain_state_e r_state;
  onehot_drain_state_e w_state_next;
  logic [NUM_WIRE-1:0] r_pending;
  logic [NUM_WIRE-1:0] w_pending_next;
  logic [NUM_WIRE-1:0] w_clear_mask;
  logic                r_drop;
  logic                w_drop_next;
  logic                w_msb_first;
  logic                w_found;
  logic                w_last;
  logic [AW-1:0]       w_index;

`ifdef ONEHOT_DRAIN_ENCODER_MSB_FIRST_EN
  assign w_msb_first = 1'b1;
`else
  assign w_msb_first = 1'b0;
`endif

  priority_encoder #(.NUM_WIRE(NUM_WIRE)) u_prio (
    .vector_i    (r_pending),
    .msb_first_i (w_msb_first),
    .index_o     (w_index),
    .found_o     (w_found)
  );

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign w_last       = w_found && ((r_pending & (r_pending - NUM_WIRE'(1))) == '0);
  assign w_clear_mask = NUM_WIRE'(1) << w_index;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_drop    <= w_drop_next;
    end
  end

  // Next-state: capture in IDLE, clear one bit per accepted beat in DRAIN.
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_drop_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.d_valid_i) begin
          if (|bus.d_i) begin
            w_pending_next = bus.d_i;
            w_state_next   = DRAIN;
          end else begin
            w_drop_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.a_ready_i) begin
          w_pending_next = r_pending & ~w_clear_mask;
          if (w_last) w_state_next = IDLE;
        end
      end
    endcase
  end

  // Handshake outputs depend on registered state only; no path from a_ready_i.
  assign bus.d_ready_o = (r_state == IDLE);
  assign bus.a_valid_o = (r_state == DRAIN);
  assign bus.a_o       = w_index;
  assign bus.a_last_o  = w_last;
  assign bus.drop_o    = r_drop;

endmodule

// File: tb/tb_onehot_drain_encoder.sv
// tb_onehot_drain_encoder
// Purpose: self-checking bench for onehot_drain_encoder; expected beats come
//          from an ordered list of set-bit indices built per captured vector.
module tb_onehot_drain_encoder;

`ifdef ONEHOT_DRAIN_ENCODER_MSB_FIRST_EN
  localparam int unsigned NW = 5;
`else
  localparam int unsigned NW = 4;
`endif
  localparam int unsigned AW = $clog2(NW);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int unsigned exp_q[$];

  onehot_drain_encoder_if #(.NUM_WIRE(NW)) bus ();

  onehot_drain_encoder #(.NUM_WIRE(NW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: expected index order of the set bits of v.
  task automatic model_load(input logic [NW-1:0] v);
    exp_q.delete();
`ifdef ONEHOT_DRAIN_ENCODER_MSB_FIRST_EN
    for (int i = int'(NW) - 1; i >= 0; i--) if (v[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < int'(NW); i++) if (v[i]) exp_q.push_back(i);
`endif
  endtask

  task automatic test_reset();
    rst_i = 1'b1; bus.d_i = '0; bus.d_valid_i = 1'b0; bus.a_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_d_ready: got %b expected 1", bus.d_ready_o); end
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b expected 0", bus.a_valid_o); end
    n_checks++; if (bus.a_o !== AW'(0)) begin n_fail++; $display("FAIL reset_a_o: got %0d expected 0", bus.a_o); end
    n_checks++; if (bus.a_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_a_last: got %b expected 0", bus.a_last_o); end
    n_checks++; if (bus.drop_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", bus.drop_o); end
  endtask

  task automatic test_single_bit();
    logic [NW-1:0] v;
    v = NW'(4'b0100);
    model_load(v);
    bus.d_i = v; bus.d_valid_i = 1'b1; bus.a_ready_i = 1'b1;
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_d_ready: got %b expected 1", bus.d_ready_o); end
    step();
    bus.d_valid_i = 1'b0;
    n_checks++; if (bus.a_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_a_valid: got %b expected 1", bus.a_valid_o); end
    n_checks++; if (bus.a_o !== AW'(exp_q[0])) begin n_fail++; $display("FAIL single_a_o: got %0d expected %0d", bus.a_o, exp_q[0]); end
    n_checks++; if (bus.a_last_o !== 1'b1) begin n_fail++; $display("FAIL single_a_last: got %b expected 1", bus.a_last_o); end
    step();
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_done_valid: got %b expected 0", bus.a_valid_o); end
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_done_ready: got %b expected 1", bus.d_ready_o); end
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] v;
    logic rdy;
    logic exp_last;
    int guard;
    v = NW'(4'b1011);
    model_load(v);
    bus.d_i = v; bus.d_valid_i = 1'b1; bus.a_ready_i = 1'b0;
    step();
    bus.d_valid_i = 1'b0;
    rdy = 1'b1;
    guard = 0;
    while (exp_q.size() != 0) begin
      guard++;
      if (guard > 100) begin
        n_checks++; n_fail++;
        $display("FAIL bp_timeout: got %0d beats left expected 0", exp_q.size());
        break;
      end
      exp_last = (exp_q.size() == 1);
      n_checks++; if (bus.a_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_a_valid: got %b expected 1", bus.a_valid_o); end
      n_checks++; if (bus.a_o !== AW'(exp_q[0])) begin n_fail++; $display("FAIL bp_a_o: got %0d expected %0d", bus.a_o, exp_q[0]); end
      n_checks++; if (bus.a_last_o !== exp_last) begin n_fail++; $display("FAIL bp_a_last: got %b expected %b", bus.a_last_o, exp_last); end
      rdy = ~rdy;
      bus.a_ready_i = rdy;
      step();
      if (rdy) void'(exp_q.pop_front());
    end
    bus.a_ready_i = 1'b0;
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid: got %b expected 0", bus.a_valid_o); end
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_done_ready: got %b expected 1", bus.d_ready_o); end
  endtask

  task automatic test_zero_vector();
    bus.d_i = '0; bus.d_valid_i = 1'b1; bus.a_ready_i = 1'b1;
    step();
    bus.d_valid_i = 1'b0;
    n_checks++; if (bus.drop_o !== 1'b1) begin n_fail++; $display("FAIL zero_drop: got %b expected 1", bus.drop_o); end
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_a_valid: got %b expected 0", bus.a_valid_o); end
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL zero_d_ready: got %b expected 1", bus.d_ready_o); end
    step();
    n_checks++; if (bus.drop_o !== 1'b0) begin n_fail++; $display("FAIL zero_drop_pulse: got %b expected 0", bus.drop_o); end
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_a_valid_after: got %b expected 0", bus.a_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] v1;
    logic [NW-1:0] v2;
    logic exp_last;
    int guard;
    v1 = NW'(4'b0011);
    v2 = NW'(4'b1000);
    model_load(v1);
    bus.d_i = v1; bus.d_valid_i = 1'b1; bus.a_ready_i = 1'b1;
    step();
    bus.d_i = v2;
    guard = 0;
    while (exp_q.size() != 0) begin
      guard++;
      if (guard > 20) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_timeout: got %0d beats left expected 0", exp_q.size());
        break;
      end
      exp_last = (exp_q.size() == 1);
      n_checks++; if (bus.a_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_a_valid: got %b expected 1", bus.a_valid_o); end
      n_checks++; if (bus.a_o !== AW'(exp_q[0])) begin n_fail++; $display("FAIL b2b_a_o: got %0d expected %0d", bus.a_o, exp_q[0]); end
      n_checks++; if (bus.a_last_o !== exp_last) begin n_fail++; $display("FAIL b2b_a_last: got %b expected %b", bus.a_last_o, exp_last); end
      n_checks++; if (bus.d_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_d_ready_busy: got %b expected 0", bus.d_ready_o); end
      step();
      void'(exp_q.pop_front());
    end
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble_valid: got %b expected 0", bus.a_valid_o); end
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble_ready: got %b expected 1", bus.d_ready_o); end
    model_load(v2);
    step();
    bus.d_valid_i = 1'b0;
    n_checks++; if (bus.a_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v2_valid: got %b expected 1", bus.a_valid_o); end
    n_checks++; if (bus.a_o !== AW'(exp_q[0])) begin n_fail++; $display("FAIL b2b_v2_a_o: got %0d expected %0d", bus.a_o, exp_q[0]); end
    n_checks++; if (bus.a_last_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v2_last: got %b expected 1", bus.a_last_o); end
    step();
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_v2_done: got %b expected 0", bus.a_valid_o); end
  endtask

  task automatic test_reset_mid_drain();
    logic [NW-1:0] v;
    v = '1;
    model_load(v);
    bus.d_i = v; bus.d_valid_i = 1'b1; bus.a_ready_i = 1'b1;
    step();
    bus.d_valid_i = 1'b0;
    step();
    step();
    n_checks++; if (bus.a_o !== AW'(exp_q[2])) begin n_fail++; $display("FAIL rst_mid_third_a_o: got %0d expected %0d", bus.a_o, exp_q[2]); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_a_valid: got %b expected 0", bus.a_valid_o); end
    n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_d_ready: got %b expected 1", bus.d_ready_o); end
    step();
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_beats: got %b expected 0", bus.a_valid_o); end
    v = NW'(4'b0010);
    model_load(v);
    bus.d_i = v; bus.d_valid_i = 1'b1;
    step();
    bus.d_valid_i = 1'b0;
    n_checks++; if (bus.a_o !== AW'(exp_q[0])) begin n_fail++; $display("FAIL rst_mid_new_a_o: got %0d expected %0d", bus.a_o, exp_q[0]); end
    n_checks++; if (bus.a_last_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_new_last: got %b expected 1", bus.a_last_o); end
    step();
    n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_new_done: got %b expected 0", bus.a_valid_o); end
  endtask

  task automatic test_random();
    logic [NW-1:0] v;
    logic rdy;
    logic exp_last;
    int guard;
    for (int n = 0; n < 40; n++) begin
      v = NW'($urandom_range(0, (1 << NW) - 1));
      repeat ($urandom_range(0, 2)) step();
      n_checks++; if (bus.d_ready_o !== 1'b1) begin n_fail++; $display("FAIL rnd_d_ready: got %b expected 1 (vec %b)", bus.d_ready_o, v); end
      bus.d_i = v; bus.d_valid_i = 1'b1; bus.a_ready_i = 1'($urandom_range(0, 1));
      step();
      bus.d_valid_i = 1'b0;
      bus.d_i = NW'($urandom());
      if (v == '0) begin
        n_checks++; if (bus.drop_o !== 1'b1) begin n_fail++; $display("FAIL rnd_drop: got %b expected 1", bus.drop_o); end
        n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_zero_valid: got %b expected 0", bus.a_valid_o); end
        continue;
      end
      model_load(v);
      guard = 0;
      while (exp_q.size() != 0) begin
        guard++;
        if (guard > 200) begin
          n_checks++; n_fail++;
          $display("FAIL rnd_timeout: got %0d beats left expected 0 (vec %b)", exp_q.size(), v);
          break;
        end
        exp_last = (exp_q.size() == 1);
        n_checks++; if (bus.a_valid_o !== 1'b1) begin n_fail++; $display("FAIL rnd_a_valid: got %b expected 1 (vec %b)", bus.a_valid_o, v); end
        n_checks++; if (bus.a_o !== AW'(exp_q[0])) begin n_fail++; $display("FAIL rnd_a_o: got %0d expected %0d (vec %b)", bus.a_o, exp_q[0], v); end
        n_checks++; if (bus.a_last_o !== exp_last) begin n_fail++; $display("FAIL rnd_a_last: got %b expected %b (vec %b)", bus.a_last_o, exp_last, v); end
        n_checks++; if (bus.drop_o !== 1'b0) begin n_fail++; $display("FAIL rnd_drop_busy: got %b expected 0", bus.drop_o); end
        rdy = 1'($urandom_range(0, 1));
        bus.a_ready_i = rdy;
        step();
        if (rdy) void'(exp_q.pop_front());
      end
      n_checks++; if (bus.a_valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_done_valid: got %b expected 0 (vec %b)", bus.a_valid_o, v); end
    end
    bus.a_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_backpressure();
    test_zero_vector();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
